pacman_move_ctrl: RTL and testbench
===================================

# pacman_move_ctrl

Frame-rate movement controller for Pac-Man that consumes the one-pixel-wide look-ahead collision warning and owns Pac-Man's position and facing. It accumulates the warning during each video frame, then at the start of the next frame decides whether to step, and probes requested turns by presenting them as a trial `face_direction` for one frame. Its `topLeftX`, `topLeftY` and `face_direction` outputs feed the collision checker and the Pac-Man drawing path.

## Interface
- `INIT_X`, 304: reset top-left X.
- `INIT_Y`, 224: reset top-left Y.
- `STEP`, 1: pixels moved per move frame. Must be ≤ 2, the collision look-ahead distance.
- `MOVE_DIV`, 1: frames per move step. Range 1..15.
- `OBJ_W`, 30: sprite width.
- `SCREEN_W`, 640: visible width.
- `TURN_HOLD`, 8: frames a buffered turn request stays alive. Range 1..15.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse at each frame start.
- `enable` in 1: game running. When low, position, facing, state and counters freeze.
- `pacmanCollisionReq` in 1: look-ahead collision warning from the collision checker, valid during the active scan.
- `dirReqValid` in 1: one-cycle key-press strobe.
- `dirReq` in 2: requested direction. Encoding: DOWN=00, RIGHT=01, LEFT=10, UP=11.
- `topLeftX` out 11: Pac-Man top-left X, registered.
- `topLeftY` out 11: Pac-Man top-left Y, registered.
- `face_direction` out 2: direction presented to the collision checker and renderer, registered.
- `moving` out 1: high when the last start-of-frame produced a step.

## Operation
- Reset values:
  - `topLeftX`=INIT_X, `topLeftY`=INIT_Y, `face_direction`=LEFT, `moving`=0.
  - State NORMAL, no pending turn, blocked flag 0, frame divider 0.
- Blocked flag: set by any cycle with `pacmanCollisionReq`=1. Cleared in every cycle where `startOfFrame`=1; a request in that same cycle is ignored.
- Pending turn register: holds the direction and a 4-bit hold counter.
  - `dirReqValid` loads `dirReq` and reloads the counter to TURN_HOLD. A later request overwrites an earlier one.
- Start-of-frame decision, taken only when `enable`=1, using the blocked flag value from before the clear. `move` = divider==0 and not blocked. The divider counts 0..MOVE_DIV-1 and advances every start-of-frame.
- NORMAL state:
  - If `move`, step STEP pixels in `face_direction`.
  - Then, if a pending turn exists:
    - Equal to the current facing: drop it.
    - Reverse of the current facing: set facing to it immediately, drop it, no trial.
    - Otherwise: save the current facing, set facing to the pending direction, go to TRIAL.
  - If no trial starts, decrement the hold counter; at 0 the pending turn is dropped.
- TRIAL state (the frame just scanned was checked with the trial direction):
  - Not blocked: commit the turn, drop the pending turn, step in the new direction if divider==0, go to NORMAL.
  - Blocked: restore the saved facing, no step, decrement the hold counter, go to NORMAL. The turn is retried every second frame until it expires.
- Step arithmetic: 11-bit unsigned. UP/DOWN is Y∓STEP and LEFT/RIGHT is X∓STEP. Y has no wrap; the maze walls bound it.

## Timing
- Collision info gathered during frame N takes effect on outputs in the cycle after frame N+1's `startOfFrame` pulse. Latency is 1 clk from the pulse.
- Outputs change only on that cycle. They are stable for the whole scan.
- `dirReqValid` coinciding with `startOfFrame`: the decision uses the old pending value; the new request is stored afterwards.
- Reset asserted mid-frame returns all outputs to their reset values asynchronously. Operation resumes at the first `startOfFrame` after release.
- `enable` low during a trial: the trial facing is held. The decision resumes when `enable` returns.

## Configuration
- `PACMAN_TUNNEL_WRAP_EN` defined:
  - LEFT with X < STEP gives X = SCREEN_W−OBJ_W.
  - RIGHT with X+STEP > SCREEN_W−OBJ_W gives X = 0.
- Undefined: X clamps to 0 and SCREEN_W−OBJ_W. `moving`=0 when clamped.

## Structure
- `pacman_pkg`: direction typedef and encodings, state enum {NORMAL, TRIAL}, and a `reverse_dir` function.
- Sub-module `pacman_pos_step`: combinational next-position from X, Y, direction and STEP, including the wrap/clamp logic. The FSM, flags and counters stay in `pacman_move_ctrl`.

## Test plan
- Reset at X=304, Y=224. Ten start-of-frames with no collision → X=294, Y=224, face LEFT, `moving`=1.
- Collision pulsed in every frame while facing LEFT → X holds at 304, `moving`=0.
- Request UP with the UP probe blocked for 3 frames, then clear → face alternates UP/LEFT. Commit on the first unblocked trial, after which Y decrements.
- Request UP and never clear (TURN_HOLD=8) → the pending turn expires after 8 decision frames and face stays LEFT.
- Facing LEFT, request RIGHT → face becomes RIGHT at the next start-of-frame with no trial frame.
- X=0 moving LEFT: with the macro → X=610; without the macro → X=0 and `moving`=0. Also assert reset mid-frame → X=304 immediately.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man movement controller: directions, FSM states
// and the reverse-direction helper.
package pacman_pkg;

    localparam int unsigned POS_W  = 11;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic {
        NORMAL = 1'b0,
        TRIAL  = 1'b1
    } state_t;

    // The encoding pairs opposites as bitwise complements.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/pacman_pos_step.sv
// Combinational one-step position update for Pac-Man.
// Define PACMAN_TUNNEL_WRAP_EN to wrap X through the side tunnel instead of clamping.
module pacman_pos_step
    import pacman_pkg::*;
#(
    parameter int unsigned STEP     = 1,
    parameter int unsigned OBJ_W    = 30,
    parameter int unsigned SCREEN_W = 640
) (
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    input  dir_t             dir,
    output logic [POS_W-1:0] next_x_c,
    output logic [POS_W-1:0] next_y_c,
    output logic             clamped_c
);

    localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);
    localparam logic [POS_W-1:0] X_MAX  = POS_W'(SCREEN_W - OBJ_W);

    logic [POS_W:0] x_plus_c;

    always_comb begin
        next_x_c  = x;
        next_y_c  = y;
        clamped_c = 1'b0;
        x_plus_c  = {1'b0, x} + {1'b0, STEP_V};
        case (dir)
            DIR_DOWN: next_y_c = y + STEP_V;
            DIR_UP:   next_y_c = y - STEP_V;
            DIR_LEFT: begin
                if (x < STEP_V) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                    next_x_c = X_MAX;
`else
                    next_x_c  = '0;
                    clamped_c = 1'b1;
`endif
                end else begin
                    next_x_c = x - STEP_V;
                end
            end
            DIR_RIGHT: begin
                if (x_plus_c > {1'b0, X_MAX}) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                    next_x_c = '0;
`else
                    next_x_c  = X_MAX;
                    clamped_c = 1'b1;
`endif
                end else begin
                    next_x_c = x_plus_c[POS_W-1:0];
                end
            end
            default: next_x_c = x;
        endcase
    end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Frame-rate Pac-Man movement controller with turn probing via trial facing.
// Tunnel wrap of X is selected with PACMAN_TUNNEL_WRAP_EN (see pacman_pos_step).
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned INIT_X    = 304,
    parameter int unsigned INIT_Y    = 224,
    parameter int unsigned STEP      = 1,
    parameter int unsigned MOVE_DIV  = 1,
    parameter int unsigned OBJ_W     = 30,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned TURN_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic             enable,
    input  logic             pacmanCollisionReq,
    input  logic             dirReqValid,
    input  logic [1:0]       dirReq,
    output logic [POS_W-1:0] topLeftX,
    output logic [POS_W-1:0] topLeftY,
    output logic [1:0]       face_direction,
    output logic             moving
);

    localparam logic [POS_W-1:0]  X_RST     = POS_W'(INIT_X);
    localparam logic [POS_W-1:0]  Y_RST     = POS_W'(INIT_Y);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(TURN_HOLD);
    localparam logic [HOLD_W-1:0] DIV_LAST  = HOLD_W'(MOVE_DIV - 1);

    state_t            state_q, state_d;
    dir_t              face_q, face_d, saved_q, saved_d, pend_dir_q, pend_dir_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic              moving_q, moving_d, blocked_q, blocked_d;
    logic              pend_v_q, pend_v_d;
    logic [HOLD_W-1:0] pend_hold_q, pend_hold_d, div_q, div_d;
    logic [POS_W-1:0]  next_x_c, next_y_c;
    logic              clamped_c, move_c;

    pacman_pos_step #(
        .STEP     (STEP),
        .OBJ_W    (OBJ_W),
        .SCREEN_W (SCREEN_W)
    ) u_pos_step (
        .x         (x_q),
        .y         (y_q),
        .dir       (face_q),
        .next_x_c  (next_x_c),
        .next_y_c  (next_y_c),
        .clamped_c (clamped_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= NORMAL;
            face_q      <= DIR_LEFT;
            saved_q     <= DIR_LEFT;
            x_q         <= X_RST;
            y_q         <= Y_RST;
            moving_q    <= 1'b0;
            blocked_q   <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_dir_q  <= DIR_DOWN;
            pend_hold_q <= '0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            face_q      <= face_d;
            saved_q     <= saved_d;
            x_q         <= x_d;
            y_q         <= y_d;
            moving_q    <= moving_d;
            blocked_q   <= blocked_d;
            pend_v_q    <= pend_v_d;
            pend_dir_q  <= pend_dir_d;
            pend_hold_q <= pend_hold_d;
            div_q       <= div_d;
        end
    end

    // Frame decision; a same-cycle key press lands after the decision.
    always_comb begin
        state_d     = state_q;
        face_d      = face_q;
        saved_d     = saved_q;
        x_d         = x_q;
        y_d         = y_q;
        moving_d    = moving_q;
        pend_v_d    = pend_v_q;
        pend_dir_d  = pend_dir_q;
        pend_hold_d = pend_hold_q;
        div_d       = div_q;
        move_c      = (div_q == '0) && !blocked_q;
        blocked_d   = startOfFrame ? 1'b0 : (blocked_q | pacmanCollisionReq);

        if (startOfFrame && enable) begin
            div_d    = (div_q == DIV_LAST) ? '0 : div_q + HOLD_W'(1);
            moving_d = 1'b0;
            case (state_q)
                NORMAL: begin
                    if (move_c) begin
                        x_d      = next_x_c;
                        y_d      = next_y_c;
                        moving_d = !clamped_c;
                    end
                    if (pend_v_q) begin
                        if (pend_dir_q == face_q) begin
                            pend_v_d = 1'b0;
                        end else if (pend_dir_q == reverse_dir(face_q)) begin
                            face_d   = pend_dir_q;
                            pend_v_d = 1'b0;
                        end else begin
                            saved_d = face_q;
                            face_d  = pend_dir_q;
                            state_d = TRIAL;
                        end
                    end
                end
                TRIAL: begin
                    state_d = NORMAL;
                    if (!blocked_q) begin
                        pend_v_d = 1'b0;
                        if (move_c) begin
                            x_d      = next_x_c;
                            y_d      = next_y_c;
                            moving_d = !clamped_c;
                        end
                    end else begin
                        face_d      = saved_q;
                        pend_hold_d = pend_hold_q - HOLD_W'(1);
                        if (pend_hold_q == HOLD_W'(1)) begin
                            pend_v_d = 1'b0;
                        end
                    end
                end
                default: state_d = NORMAL;
            endcase
        end

        if (dirReqValid) begin
            pend_v_d    = 1'b1;
            pend_dir_d  = dir_t'(dirReq);
            pend_hold_d = HOLD_INIT;
        end
    end

    assign topLeftX       = x_q;
    assign topLeftY       = y_q;
    assign face_direction = face_q;
    assign moving         = moving_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Self-checking bench for pacman_move_ctrl: directed scenarios plus random frames
// against a frame-level reference model (follows PACMAN_TUNNEL_WRAP_EN if defined).
module tb_pacman_move_ctrl;

    localparam int X_MAX     = 610;
    localparam int STEP      = 1;
    localparam int TURN_HOLD = 8;
    localparam int MOVE_DIV  = 1;
    localparam logic [1:0] D_DOWN = 2'd0, D_RIGHT = 2'd1, D_LEFT = 2'd2, D_UP = 2'd3;

    logic        clk = 1'b0;
    logic        reset, sof, en, coll, rv;
    logic [1:0]  rd;
    logic [10:0] tx, ty;
    logic [1:0]  fd;
    logic        mv;

    int checks = 0;
    int errors = 0;

    // Reference model state (frame level)
    int         mx, my, mdiv, ph;
    logic [1:0] mface, msaved, pd;
    bit         mtrial, mmoving, pv, blk_acc;

    always #5 clk = ~clk;

    pacman_move_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (sof),
        .enable             (en),
        .pacmanCollisionReq (coll),
        .dirReqValid        (rv),
        .dirReq             (rd),
        .topLeftX           (tx),
        .topLeftY           (ty),
        .face_direction     (fd),
        .moving             (mv)
    );

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("x", tx, 11'(mx));
        chk("y", ty, 11'(my));
        chk("face", {9'd0, fd}, {9'd0, mface});
        chk("moving", {10'd0, mv}, {10'd0, mmoving});
    endtask

    task automatic model_reset();
        mx = 304; my = 224; mdiv = 0; ph = 0;
        mface = D_LEFT; msaved = D_LEFT; pd = D_DOWN;
        mtrial = 0; mmoving = 0; pv = 0; blk_acc = 0;
    endtask

    function automatic bit opposite(input logic [1:0] a, input logic [1:0] b);
        return (a == D_LEFT && b == D_RIGHT) || (a == D_RIGHT && b == D_LEFT) ||
               (a == D_UP && b == D_DOWN) || (a == D_DOWN && b == D_UP);
    endfunction

    // Move one step in dir; returns 1 if Pac-Man actually moved.
    function automatic bit model_step(input logic [1:0] dir);
        int nx;
        bit moved;
        nx = mx;
        moved = 1;
        case (dir)
            D_LEFT:  nx = mx - STEP;
            D_RIGHT: nx = mx + STEP;
            D_UP:    my = (my - STEP + 2048) % 2048;
            default: my = (my + STEP) % 2048;
        endcase
`ifdef PACMAN_TUNNEL_WRAP_EN
        if (nx < 0) nx = X_MAX;
        else if (nx > X_MAX) nx = 0;
`else
        if (nx < 0) begin nx = 0; moved = 0; end
        else if (nx > X_MAX) begin nx = X_MAX; moved = 0; end
`endif
        mx = nx;
        return moved;
    endfunction

    task automatic model_sof(input bit blk);
        bit go;
        go = (mdiv == 0) && !blk;
        mdiv = (mdiv + 1) % MOVE_DIV;
        mmoving = 0;
        if (!mtrial) begin
            if (go) mmoving = model_step(mface);
            if (pv) begin
                if (pd == mface) pv = 0;
                else if (opposite(pd, mface)) begin mface = pd; pv = 0; end
                else begin msaved = mface; mface = pd; mtrial = 1; end
            end
        end else begin
            mtrial = 0;
            if (!blk) begin
                pv = 0;
                if (go) mmoving = model_step(mface);
            end else begin
                mface = msaved;
                ph--;
                if (ph == 0) pv = 0;
            end
        end
    endtask

    task automatic model_load(input logic [1:0] d);
        pv = 1; pd = d; ph = TURN_HOLD;
    endtask

    // One frame: sof pulse then 8 scan cycles.
    // cmode: 0 no collision, 1 always, 2 only while probing a turn, 3 random.
    task automatic frame(input int cmode, input bit e, input bit req,
                         input logic [1:0] d, input bit req_at_sof);
        bit c;
        int cpos;
        @(negedge clk);
        sof  = 1'b1;
        en   = e;
        coll = 1'($urandom_range(0, 1));
        rv   = req && req_at_sof;
        rd   = d;
        @(posedge clk);
        if (e) model_sof(blk_acc);
        blk_acc = 0;
        if (req && req_at_sof) model_load(d);
        #1 check_all();
        case (cmode)
            0:       c = 0;
            1:       c = 1;
            2:       c = mtrial;
            default: c = 1'($urandom_range(0, 1));
        endcase
        cpos = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sof  = 1'b0;
            rv   = req && !req_at_sof && (i == 3);
            coll = c && (i == cpos);
            @(posedge clk);
            if (coll) blk_acc = 1;
            if (rv) model_load(d);
        end
        @(negedge clk);
        rv   = 1'b0;
        coll = 1'b0;
        chk("x_stable", tx, 11'(mx));
        chk("face_stable", {9'd0, fd}, {9'd0, mface});
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; sof = 1'b0; en = 1'b1; coll = 1'b0; rv = 1'b0; rd = D_DOWN;
        model_reset();
        #2;
        chk("rst_x", tx, 11'd304);
        chk("rst_y", ty, 11'd224);
        chk("rst_face", {9'd0, fd}, {9'd0, D_LEFT});
        chk("rst_moving", {10'd0, mv}, 11'd0);
        @(negedge clk);
        reset = 1'b0;

        // Free running left
        repeat (10) frame(0, 1, 0, D_DOWN, 0);
        chk("ten_x", tx, 11'd294);
        chk("ten_face", {9'd0, fd}, {9'd0, D_LEFT});
        chk("ten_moving", {10'd0, mv}, 11'd1);

        // Wall ahead every frame
        repeat (5) frame(1, 1, 0, D_DOWN, 0);
        chk("blocked_x", tx, 11'd293);
        chk("blocked_moving", {10'd0, mv}, 11'd0);

        // Turn UP, probe blocked three times, then committed
        frame(0, 1, 1, D_UP, 0);
        frame(2, 1, 0, D_DOWN, 0);
        chk("probe1_face", {9'd0, fd}, {9'd0, D_UP});
        frame(2, 1, 0, D_DOWN, 0);
        chk("restore1_face", {9'd0, fd}, {9'd0, D_LEFT});
        repeat (4) frame(2, 1, 0, D_DOWN, 0);
        frame(0, 1, 0, D_DOWN, 0);
        chk("probe4_face", {9'd0, fd}, {9'd0, D_UP});
        frame(0, 1, 0, D_DOWN, 0);
        chk("commit_face", {9'd0, fd}, {9'd0, D_UP});
        chk("commit_y", ty, 11'd223);
        frame(0, 1, 0, D_DOWN, 0);
        chk("after_commit_y", ty, 11'd222);

        // Reset in the middle of a scan
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_x", tx, 11'd304);
        chk("midrst_y", ty, 11'd224);
        chk("midrst_face", {9'd0, fd}, {9'd0, D_LEFT});
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Turn that never clears expires
        frame(0, 1, 1, D_UP, 0);
        repeat (18) frame(2, 1, 0, D_DOWN, 0);
        repeat (3) begin
            frame(0, 1, 0, D_DOWN, 0);
            chk("expired_face", {9'd0, fd}, {9'd0, D_LEFT});
        end

        // Reverse is immediate
        frame(0, 1, 1, D_RIGHT, 0);
        frame(0, 1, 0, D_DOWN, 0);
        chk("reverse_face", {9'd0, fd}, {9'd0, D_RIGHT});
        frame(0, 1, 0, D_DOWN, 0);
        chk("reverse_hold", {9'd0, fd}, {9'd0, D_RIGHT});

        // Request landing on the same cycle as the frame pulse
        frame(0, 1, 1, D_UP, 1);
        frame(0, 1, 0, D_DOWN, 0);
        chk("sof_req_face", {9'd0, fd}, {9'd0, D_UP});

        // Random frames
        repeat (150) begin
            bit e, r, s;
            logic [1:0] d;
            e = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 3) == 0);
            s = 1'($urandom_range(0, 1));
            d = 2'($urandom_range(0, 3));
            frame(3, e, r, d, s);
        end

        // Left edge
        hard_reset();
        repeat (305) frame(0, 1, 0, D_DOWN, 0);
`ifdef PACMAN_TUNNEL_WRAP_EN
        chk("edge_x", tx, 11'd610);
        chk("edge_moving", {10'd0, mv}, 11'd1);
`else
        chk("edge_x", tx, 11'd0);
        chk("edge_moving", {10'd0, mv}, 11'd0);
`endif
        frame(0, 1, 0, D_DOWN, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
